// File: rtl/mimc_cipher_round_ctrl_pkg.sv
// ============================================================================
// Module : mimc_pkg
// Brief  : Shared constants and FSM state encoding for the MiMC-7 controller.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package mimc_pkg;

    localparam int          MIMC_N_BITS   = 254;
    localparam int          MIMC_N_ROUNDS = 91;
    localparam logic [253:0] BN254_PRIME  =
        254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RC_FETCH = 3'd1,
        ROUND    = 3'd2,
        FINAL    = 3'd3,
        OUT      = 3'd4
    } ctrl_state_t;

endpackage : mimc_pkg

`default_nettype wire

// File: rtl/mimc_cipher_round_ctrl_if.sv
// ============================================================================
// Module : mimc_cipher_round_ctrl_if
// Brief  : Plaintext/key input and ciphertext output handshake bundle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface mimc_cipher_round_ctrl_if #(
    parameter int N_BITS = mimc_pkg::MIMC_N_BITS
);
    logic              in_valid;
    logic              in_ready;
    logic [N_BITS-1:0] in_data;
    logic [N_BITS-1:0] in_key;
    logic              out_valid;
    logic              out_ready;
    logic [N_BITS-1:0] out_data;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface : mimc_cipher_round_ctrl_if

`default_nettype wire

// File: rtl/mimc_cipher_round_ctrl_mod_add.sv
// ============================================================================
// Module : mimc_mod_add
// Brief  : Combinational a+b mod PRIME for operands already reduced below PRIME.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mimc_mod_add #(
    parameter int                N_BITS = mimc_pkg::MIMC_N_BITS,
    parameter logic [N_BITS-1:0] PRIME  = N_BITS'(mimc_pkg::BN254_PRIME)
) (
    input  wire logic [N_BITS-1:0] a_i,
    input  wire logic [N_BITS-1:0] b_i,
    output logic      [N_BITS-1:0] sum_o
);

    logic [N_BITS:0] w_sum;
    logic [N_BITS:0] w_diff;

    // One extra bit keeps the carry so a single conditional subtract suffices.
    assign w_sum  = {1'b0, a_i} + {1'b0, b_i};
    assign w_diff = w_sum - {1'b0, PRIME};
    assign sum_o  = (w_sum >= {1'b0, PRIME}) ? w_diff[N_BITS-1:0] : w_sum[N_BITS-1:0];

endmodule : mimc_mod_add

`default_nettype wire

// File: rtl/mimc_cipher_round_ctrl.sv
// ============================================================================
// Module : mimc_cipher_round_ctrl
// Brief  : MiMC-7 round sequencer: fetches round constants, iterates the
//          external round datapath and applies the final key addition.
//          Optional round watchdog enabled by macro MIMC_CTRL_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mimc_cipher_round_ctrl
    import mimc_pkg::*;
#(
    parameter int                N_BITS         = MIMC_N_BITS,
    parameter int                N_ROUNDS       = MIMC_N_ROUNDS,
    parameter logic [N_BITS-1:0] PRIME          = N_BITS'(BN254_PRIME),
    parameter int                RC_IDX_W       = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1,
    parameter int                TIMEOUT_CYCLES = 4096
) (
    input  wire logic                clk,
    input  wire logic                rst,
    mimc_cipher_round_ctrl_if.slave  bus,
    output logic      [RC_IDX_W-1:0] rc_idx,
    input  wire logic [N_BITS-1:0]   rc_data,
    output logic                     round_en,
    output logic      [N_BITS-1:0]   round_in,
    output logic      [N_BITS-1:0]   round_rc,
    output logic      [N_BITS-1:0]   round_key,
    input  wire logic [N_BITS-1:0]   round_out,
    input  wire logic                round_done
`ifdef MIMC_CTRL_TIMEOUT_EN
    ,
    output logic                     err
`endif
);

    localparam logic [RC_IDX_W-1:0] c_LAST_RND = RC_IDX_W'(N_ROUNDS - 1);

    generate
        if (N_ROUNDS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("mimc_cipher_round_ctrl: N_ROUNDS and TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    ctrl_state_t         state_q;
    logic [N_BITS-1:0]   state_reg_q;
    logic [N_BITS-1:0]   key_q;
    logic [N_BITS-1:0]   rc_q;
    logic [N_BITS-1:0]   out_data_q;
    logic [RC_IDX_W-1:0] rnd_q;
    logic [RC_IDX_W-1:0] rc_idx_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                round_en_q;

    logic [N_BITS-1:0]   final_sum_d;
    logic [RC_IDX_W-1:0] rnd_d;

`ifdef MIMC_CTRL_TIMEOUT_EN
    localparam int                WD_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]   c_WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    assign err = err_q;
`endif

    assign rnd_d = rnd_q + RC_IDX_W'(1);

    mimc_mod_add #(
        .N_BITS (N_BITS),
        .PRIME  (PRIME)
    ) u_final_add (
        .a_i    (state_reg_q),
        .b_i    (key_q),
        .sum_o  (final_sum_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            state_reg_q <= '0;
            key_q       <= '0;
            rc_q        <= '0;
            out_data_q  <= '0;
            rnd_q       <= '0;
            rc_idx_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            round_en_q  <= 1'b0;
`ifdef MIMC_CTRL_TIMEOUT_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        state_reg_q <= bus.in_data;
                        key_q       <= bus.in_key;
                        rnd_q       <= '0;
                        rc_idx_q    <= '0;
                        in_ready_q  <= 1'b0;
                        state_q     <= RC_FETCH;
                    end
                end

                RC_FETCH: begin
                    rc_q       <= rc_data;
                    round_en_q <= 1'b1;
`ifdef MIMC_CTRL_TIMEOUT_EN
                    wd_q       <= '0;
`endif
                    state_q    <= ROUND;
                end

                ROUND: begin
                    if (round_done) begin
                        // Dropping en here guarantees a low gap before the next round.
                        state_reg_q <= round_out;
                        round_en_q  <= 1'b0;
                        if (rnd_q == c_LAST_RND) begin
                            state_q <= FINAL;
                        end else begin
                            rnd_q    <= rnd_d;
                            rc_idx_q <= rnd_d;
                            state_q  <= RC_FETCH;
                        end
                    end
`ifdef MIMC_CTRL_TIMEOUT_EN
                    else if (wd_q == c_WD_LAST) begin
                        err_q      <= 1'b1;
                        round_en_q <= 1'b0;
                        in_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
`endif
                end

                FINAL: begin
                    out_data_q  <= final_sum_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end

                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    round_en_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign rc_idx        = rc_idx_q;
    assign round_en      = round_en_q;
    assign round_in      = state_reg_q;
    assign round_rc      = rc_q;
    assign round_key     = key_q;

endmodule : mimc_cipher_round_ctrl

`default_nettype wire

// File: tb/tb_mimc_cipher_round_ctrl.sv
// ============================================================================
// Module : tb_mimc_cipher_round_ctrl
// Brief  : Toy-field (p=11, 3 rounds) bench with behavioural round block and
//          queue scoreboard; watchdog test when MIMC_CTRL_TIMEOUT_EN is set.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mimc_cipher_round_ctrl;

    localparam int         NB = 4;
    localparam int         NR = 3;
    localparam int         LR = 2;
    localparam logic [3:0] P  = 4'd11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mimc_cipher_round_ctrl_if #(.N_BITS(NB)) bus();

    logic [1:0] rc_idx;
    logic [3:0] rc_data, round_in, round_rc, round_key, round_out;
    logic       round_en, round_done;
`ifdef MIMC_CTRL_TIMEOUT_EN
    logic       err;
`endif

    mimc_cipher_round_ctrl #(
        .N_BITS         (NB),
        .N_ROUNDS       (NR),
        .PRIME          (P),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .rc_idx     (rc_idx),
        .rc_data    (rc_data),
        .round_en   (round_en),
        .round_in   (round_in),
        .round_rc   (round_rc),
        .round_key  (round_key),
        .round_out  (round_out),
`ifdef MIMC_CTRL_TIMEOUT_EN
        .err        (err),
`endif
        .round_done (round_done)
    );

    // Constant store and behavioural round block (x+k+c)^7 mod 11.
    logic [3:0] rc_mem [4];
    assign rc_data = rc_mem[rc_idx];

    bit         ovr_en  = 1'b0;
    logic [3:0] ovr_val = 4'd0;
    bit         no_done = 1'b0;

    function automatic logic [3:0] pow7(logic [3:0] x, logic [3:0] k, logic [3:0] c);
        int v;
        int r;
        v = (int'(x) + int'(k) + int'(c)) % 11;
        r = 1;
        repeat (7) r = (r * v) % 11;
        return 4'(r);
    endfunction

    logic en_d;
    int   lat_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            en_d       <= 1'b0;
            lat_cnt    <= 0;
            round_done <= 1'b0;
            round_out  <= 4'd0;
        end else begin
            en_d       <= round_en;
            round_done <= 1'b0;
            if (round_en && !en_d) begin
                lat_cnt <= LR;
            end else if (lat_cnt > 0) begin
                lat_cnt <= lat_cnt - 1;
                if (lat_cnt == 1 && !no_done) begin
                    round_done <= 1'b1;
                    round_out  <= ovr_en ? ovr_val : pow7(round_in, round_key, round_rc);
                end
            end
        end
    end

    logic [3:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(logic [3:0] d, logic [3:0] k, logic [3:0] exp, bit push);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_key   = k;
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic collect(int stall);
        int         n;
        bit         saw_ready;
        logic [3:0] exp;
        logic [3:0] held;
        n = 0;
        saw_ready = 1'b0;
        while (!bus.out_valid && n < 200) begin
            if (bus.in_ready) saw_ready = 1'b1;
            @(negedge clk);
            n++;
        end
        check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
        check("in_ready_low_busy", 32'(saw_ready), 32'd0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
        check("out_data", 32'(bus.out_data), 32'(exp));
        held = bus.out_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.out_valid), 32'd1);
            check("stall_data", 32'(bus.out_data), 32'(held));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("out_valid_drop", 32'(bus.out_valid), 32'd0);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'd0;
        bus.in_key    = 4'd0;
        bus.out_ready = 1'b0;
        rc_mem[0] = 4'd0; rc_mem[1] = 4'd1; rc_mem[2] = 4'd2; rc_mem[3] = 4'd0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_round_en", 32'(round_en), 32'd0);
        check("rst_rc_idx", 32'(rc_idx), 32'd0);
`ifdef MIMC_CTRL_TIMEOUT_EN
        check("rst_err", 32'(err), 32'd0);
`endif

        // Reference vector: rounds 2, 8, 7, then 7+3 = 10.
        send(4'd5, 4'd3, 4'hA, 1'b1);
        collect(0);

        rc_mem[1] = 4'd0; rc_mem[2] = 4'd0;
        send(4'd0, 4'd0, 4'h0, 1'b1);
        collect(0);

        // Final addition wrap and no-wrap.
        rc_mem[1] = 4'd1; rc_mem[2] = 4'd2;
        ovr_en = 1'b1; ovr_val = 4'd9;
        send(4'd5, 4'd3, 4'd1, 1'b1);
        collect(0);
        ovr_val = 4'd7;
        send(4'd5, 4'd3, 4'hA, 1'b1);
        collect(0);
        ovr_en = 1'b0;

        // Backpressure with a stray in_valid while busy.
        send(4'd5, 4'd3, 4'hA, 1'b1);
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 4'd1; bus.in_key = 4'd1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        collect(20);

        // Reset in the middle of round 2, then a clean transaction.
        send(4'd5, 4'd3, 4'h0, 1'b0);
        n = 0;
        while (!(round_en && rc_idx == 2'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_round2", 32'(round_en && rc_idx == 2'd1), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("midrst_round_en", 32'(round_en), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(4'd5, 4'd3, 4'hA, 1'b1);
        collect(0);

`ifdef MIMC_CTRL_TIMEOUT_EN
        no_done = 1'b1;
        send(4'd5, 4'd3, 4'h0, 1'b0);
        n = 0;
        while (!round_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!err && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wd_cycles", 32'(n), 32'd16);
        check("wd_err", 32'(err), 32'd1);
        check("wd_out_valid", 32'(bus.out_valid), 32'd0);
        check("wd_in_ready", 32'(bus.in_ready), 32'd1);
        check("wd_round_en", 32'(round_en), 32'd0);
        repeat (3) @(negedge clk);
        check("wd_err_sticky", 32'(err), 32'd1);
        no_done = 1'b0;
`endif

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mimc_cipher_round_ctrl

`default_nettype wire
